// File: rtl/pulse_timer_pkg.sv
// Shared types and constants for the pulse timer.
// Holds the per-channel FSM state encoding and mode selects.
package pulse_timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_CONT    = 1'b0;
    localparam logic MODE_ONESHOT = 1'b1;

endpackage

// File: rtl/pulse_timer_chan.sv
// One independent timer channel: IDLE/RUN/DONE FSM with count,
// terminal-count wrap strobe and compare-based pulse output.
module pulse_timer_chan
    import pulse_timer_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             en,
    input  logic             oneshot,
    input  logic [WIDTH-1:0] period,
    input  logic [WIDTH-1:0] compare,
    output logic [WIDTH-1:0] count,
    output logic             out,
    output logic             wrap,
    output logic             busy
);

    state_t state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            count <= '0;
            wrap  <= 1'b0;
        end else if (start) begin
            state <= RUN;
            count <= '0;
            wrap  <= 1'b0;
        end else begin
            wrap <= 1'b0;
            case (state)
                RUN: begin
                    if (en) begin
                        // >= so a period lowered below count wraps at once
                        if (count >= period) begin
                            count <= '0;
                            wrap  <= 1'b1;
                            if (oneshot == MODE_ONESHOT) begin
                                state <= DONE;
                            end
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= state;
                end
            endcase
        end
    end

    assign busy = (state == RUN);
    assign out  = (state == RUN) && (count < compare);

endmodule

// File: rtl/pulse_timer.sv
// Multi-channel pulse timer: CHANNELS independent timer channels
// with flattened per-channel period/compare/count vectors.
module pulse_timer
    import pulse_timer_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS-1:0]       start,
    input  logic [CHANNELS-1:0]       en,
    input  logic [CHANNELS-1:0]       oneshot,
    input  logic [CHANNELS*WIDTH-1:0] period,
    input  logic [CHANNELS*WIDTH-1:0] compare,
    output logic [CHANNELS*WIDTH-1:0] count,
    output logic [CHANNELS-1:0]       out,
    output logic [CHANNELS-1:0]       wrap,
    output logic [CHANNELS-1:0]       busy
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        pulse_timer_chan #(
            .WIDTH(WIDTH)
        ) u_chan (
            .clk    (clk),
            .rst    (rst),
            .start  (start[i]),
            .en     (en[i]),
            .oneshot(oneshot[i]),
            .period (period[i*WIDTH +: WIDTH]),
            .compare(compare[i*WIDTH +: WIDTH]),
            .count  (count[i*WIDTH +: WIDTH]),
            .out    (out[i]),
            .wrap   (wrap[i]),
            .busy   (busy[i])
        );
    end

endmodule

// File: tb/tb_pulse_timer.sv
// Directed self-checking bench for pulse_timer (WIDTH=8, CHANNELS=4).
module tb_pulse_timer;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  start;
    logic [3:0]  en;
    logic [3:0]  oneshot;
    logic [31:0] period;
    logic [31:0] compare;
    logic [31:0] count;
    logic [3:0]  out;
    logic [3:0]  wrap;
    logic [3:0]  busy;

    int pass_cnt  = 0;
    int total_cnt = 0;

    pulse_timer #(
        .WIDTH(8),
        .CHANNELS(4)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .en     (en),
        .oneshot(oneshot),
        .period (period),
        .compare(compare),
        .count  (count),
        .out    (out),
        .wrap   (wrap),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    // advance one edge; outputs are sampled 1 time unit after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] cnt(input int ch);
        return count[ch*8 +: 8];
    endfunction

    task automatic setup(input int ch, input int p, input int c, input logic os);
        period[ch*8 +: 8]  = 8'(p);
        compare[ch*8 +: 8] = 8'(c);
        oneshot[ch]        = os;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 4'hF;
        en    = 4'hF;
        step();
        step();
        total_cnt++;
        if (count !== 32'h0)
            $display("FAIL reset_count got=%h exp=%h", count, 32'h0);
        else pass_cnt++;
        total_cnt++;
        if ({busy, out, wrap} !== 12'h0)
            $display("FAIL reset_flags got=%h exp=%h", {busy, out, wrap}, 12'h0);
        else pass_cnt++;
        rst   = 1'b0;
        start = 4'h0;
        en    = 4'h0;
        step();
        total_cnt++;
        if (busy !== 4'h0)
            $display("FAIL reset_idle_busy got=%b exp=%b", busy, 4'h0);
        else pass_cnt++;
    endtask

    task automatic test_continuous();
        int ec[8] = '{1, 2, 3, 0, 1, 2, 3, 0};
        logic ew[8] = '{0, 0, 0, 1, 0, 0, 0, 1};
        logic eo[8] = '{1, 0, 0, 1, 1, 0, 0, 1};
        setup(0, 3, 2, 1'b0);
        start[0] = 1'b1;
        en[0]    = 1'b1;
        step();
        start[0] = 1'b0;
        total_cnt++;
        if (cnt(0) !== 8'd0 || busy[0] !== 1'b1 || wrap[0] !== 1'b0 || out[0] !== 1'b1)
            $display("FAIL cont_start got=%0d/%b/%b/%b exp=0/1/0/1",
                     cnt(0), busy[0], wrap[0], out[0]);
        else pass_cnt++;
        for (int i = 0; i < 8; i++) begin
            step();
            total_cnt++;
            if (cnt(0) !== 8'(ec[i]) || wrap[0] !== ew[i] || out[0] !== eo[i])
                $display("FAIL cont_seq[%0d] got=%0d/%b/%b exp=%0d/%b/%b",
                         i, cnt(0), wrap[0], out[0], ec[i], ew[i], eo[i]);
            else pass_cnt++;
        end
        en[0] = 1'b0;
    endtask

    task automatic test_oneshot();
        int ec[6] = '{1, 2, 0, 0, 0, 0};
        logic ew[6] = '{0, 0, 1, 0, 0, 0};
        logic eb[6] = '{1, 1, 0, 0, 0, 0};
        int nwrap = 0;
        setup(1, 2, 1, 1'b1);
        start[1] = 1'b1;
        en[1]    = 1'b1;
        step();
        start[1] = 1'b0;
        total_cnt++;
        if (cnt(1) !== 8'd0 || busy[1] !== 1'b1)
            $display("FAIL os_start got=%0d/%b exp=0/1", cnt(1), busy[1]);
        else pass_cnt++;
        for (int i = 0; i < 6; i++) begin
            step();
            if (wrap[1]) nwrap++;
            total_cnt++;
            if (cnt(1) !== 8'(ec[i]) || wrap[1] !== ew[i] || busy[1] !== eb[i])
                $display("FAIL os_seq[%0d] got=%0d/%b/%b exp=%0d/%b/%b",
                         i, cnt(1), wrap[1], busy[1], ec[i], ew[i], eb[i]);
            else pass_cnt++;
        end
        total_cnt++;
        if (nwrap !== 1 || out[1] !== 1'b0)
            $display("FAIL os_done got=%0d/%b exp=1/0", nwrap, out[1]);
        else pass_cnt++;
        en[1] = 1'b0;
    endtask

    task automatic test_enable();
        logic ee[8] = '{1, 0, 0, 1, 1, 1, 1, 1};
        int ec[8] = '{1, 1, 1, 2, 3, 4, 5, 0};
        logic ew[8] = '{0, 0, 0, 0, 0, 0, 0, 1};
        setup(2, 5, 10, 1'b0);
        start[2] = 1'b1;
        en[2]    = 1'b1;
        step();
        start[2] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            en[2] = ee[i];
            step();
            total_cnt++;
            if (cnt(2) !== 8'(ec[i]) || wrap[2] !== ew[i] || out[2] !== 1'b1)
                $display("FAIL en_seq[%0d] got=%0d/%b/%b exp=%0d/%b/1",
                         i, cnt(2), wrap[2], out[2], ec[i], ew[i]);
            else pass_cnt++;
        end
        en[2] = 1'b0;
    endtask

    task automatic test_start_at_terminal();
        setup(3, 2, 0, 1'b0);
        start[3] = 1'b1;
        en[3]    = 1'b1;
        step();
        start[3] = 1'b0;
        step();
        step();
        total_cnt++;
        if (cnt(3) !== 8'd2 || out[3] !== 1'b0)
            $display("FAIL term_pre got=%0d/%b exp=2/0", cnt(3), out[3]);
        else pass_cnt++;
        start[3] = 1'b1;
        step();
        start[3] = 1'b0;
        total_cnt++;
        if (cnt(3) !== 8'd0 || wrap[3] !== 1'b0 || busy[3] !== 1'b1)
            $display("FAIL term_start got=%0d/%b/%b exp=0/0/1",
                     cnt(3), wrap[3], busy[3]);
        else pass_cnt++;
        step();
        total_cnt++;
        if (cnt(3) !== 8'd1)
            $display("FAIL term_after got=%0d exp=1", cnt(3));
        else pass_cnt++;
        en[3] = 1'b0;
    endtask

    task automatic test_period_change();
        setup(1, 10, 20, 1'b0);
        start[1] = 1'b1;
        en[1]    = 1'b1;
        step();
        start[1] = 1'b0;
        repeat (6) step();
        period[1*8 +: 8] = 8'd3;
        step();
        total_cnt++;
        if (cnt(1) !== 8'd0 || wrap[1] !== 1'b1 || busy[1] !== 1'b1)
            $display("FAIL per_shrink got=%0d/%b/%b exp=0/1/1",
                     cnt(1), wrap[1], busy[1]);
        else pass_cnt++;
        step();
        total_cnt++;
        if (cnt(1) !== 8'd1 || wrap[1] !== 1'b0)
            $display("FAIL per_after got=%0d/%b exp=1/0", cnt(1), wrap[1]);
        else pass_cnt++;
        en[1] = 1'b0;
    endtask

    task automatic test_rst_midrun();
        setup(0, 20, 10, 1'b0);
        start[0] = 1'b1;
        en[0]    = 1'b1;
        step();
        start[0] = 1'b0;
        repeat (7) step();
        total_cnt++;
        if (cnt(0) !== 8'd7 || out[0] !== 1'b1)
            $display("FAIL rst_pre got=%0d/%b exp=7/1", cnt(0), out[0]);
        else pass_cnt++;
        rst   = 1'b1;
        start = 4'hF;
        step();
        rst   = 1'b0;
        start = 4'h0;
        total_cnt++;
        if (cnt(0) !== 8'd0 || busy !== 4'h0 || out !== 4'h0 || wrap !== 4'h0)
            $display("FAIL rst_mid got=%0d/%b/%b/%b exp=0/0000/0000/0000",
                     cnt(0), busy, out, wrap);
        else pass_cnt++;
        step();
        total_cnt++;
        if (count !== 32'h0 || busy !== 4'h0)
            $display("FAIL rst_idle got=%h/%b exp=0/0000", count, busy);
        else pass_cnt++;
        en[0] = 1'b0;
    endtask

    task automatic test_multi();
        int p[4] = '{0, 1, 254, 255};
        int nw[4] = '{0, 0, 0, 0};
        int bad[4] = '{0, 0, 0, 0};
        int ew[4] = '{512, 256, 2, 2};
        for (int c = 0; c < 4; c++) setup(c, p[c], 8'd255, 1'b0);
        start = 4'hF;
        en    = 4'hF;
        step();
        start = 4'h0;
        for (int s = 1; s <= 512; s++) begin
            step();
            for (int c = 0; c < 4; c++) begin
                if (wrap[c]) begin
                    nw[c]++;
                    if (s % (p[c] + 1) != 0) bad[c]++;
                end
            end
        end
        for (int c = 0; c < 4; c++) begin
            total_cnt++;
            if (nw[c] !== ew[c] || bad[c] !== 0)
                $display("FAIL multi_ch%0d got=%0d wraps/%0d misaligned exp=%0d/0",
                         c, nw[c], bad[c], ew[c]);
            else pass_cnt++;
        end
        en = 4'h0;
    endtask

    initial begin
        rst     = 1'b1;
        start   = '0;
        en      = '0;
        oneshot = '0;
        period  = '0;
        compare = '0;
        test_reset();
        test_continuous();
        test_oneshot();
        test_enable();
        test_start_at_terminal();
        test_period_change();
        test_rst_midrun();
        test_multi();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/pulse_timer.md
PULSE_TIMER -- requirements
Module: pulse_timer

Interface
REQ-001 Parameter WIDTH, default 16, SHALL set the counter width per channel (2..32).
REQ-002 Parameter CHANNELS, default 4, SHALL set the number of independent timer channels (1..16).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-005 start  input  CHANNELS  SHALL be per-channel one-cycle restart strobes.
REQ-006 en  input  CHANNELS  SHALL be per-channel count enables (0 = pause).
REQ-007 oneshot  input  CHANNELS  SHALL select the mode per channel: 0 = continuous, 1 = one-shot.
REQ-008 period  input  CHANNELS x WIDTH  SHALL be the terminal count per channel.
REQ-009 compare  input  CHANNELS x WIDTH  SHALL be the pulse-width threshold per channel.
REQ-010 count  output  CHANNELS x WIDTH  SHALL be the registered current count per channel.
REQ-011 out  output  CHANNELS  SHALL be the pulse output per channel.
REQ-012 wrap  output  CHANNELS  SHALL be a registered one-cycle terminal-count strobe per channel.
REQ-013 busy  output  CHANNELS  SHALL be high while the channel is in RUN.

Function
REQ-014 Each channel SHALL run an FSM with states IDLE, RUN and DONE; channels SHALL be fully independent.
REQ-015 On start=1, from any state, the next edge SHALL set state=RUN and count=0, with wrap=0 on that edge.
REQ-016 In RUN with en=1 and count < period, the next edge SHALL set count=count+1 (no saturation needed).
REQ-017 In RUN with en=1 and count >= period, the next edge SHALL set count=0 and wrap=1 for exactly that cycle.
REQ-018 After a wrap edge, continuous mode SHALL remain in RUN and one-shot mode SHALL go to DONE, holding count=0.
REQ-019 In RUN with en=0, count and state SHALL hold and wrap SHALL be 0.
REQ-020 IDLE and DONE SHALL hold count; only start leaves them; busy=0 in both.
REQ-021 out SHALL equal (state==RUN) AND (count < compare), decoded from registered state/count; out SHALL be 0 when compare=0 and SHALL be 1 for the whole of RUN when compare > period.
REQ-022 period=0 with en=1 SHALL produce wrap on every cycle in continuous mode.
REQ-023 period or compare changed mid-RUN SHALL take effect on the next edge; count > new period SHALL wrap on the next enabled edge (the >= rule).
REQ-024 start coinciding with a terminal count SHALL win: count=0, wrap=0, state=RUN.
REQ-025 A oneshot change mid-RUN SHALL apply at the next wrap.

Reset
REQ-026 rst=1 SHALL, on the next edge, set every channel to IDLE with count=0, wrap=0, busy=0, out=0.
REQ-027 rst SHALL take priority over start and en, including mid-RUN.

Structure
REQ-028 The package pulse_timer_pkg SHALL hold the state enum (IDLE, RUN, DONE) and the mode constants.
REQ-029 The sub-module pulse_timer_chan SHALL implement one channel; pulse_timer SHALL instantiate CHANNELS copies via generate and flatten the vectors.

Verification
REQ-030 Continuous, period=3, compare=2, en=1, start at cycle 0: count 0,1,2,3,0,...; wrap high when count returns to 0 (every 4 cycles); out pattern 1,1,0,0.
REQ-031 One-shot, period=2: count 0,1,2,0, then DONE; exactly one wrap; busy falls with the wrap cycle; no further change until the next start.
REQ-032 en toggles 1,0,0,1 in RUN, period=5: count holds for two cycles, and wrap is delayed by exactly 2 cycles.
REQ-033 start asserted on the same edge where count=period: count=0, wrap=0, state stays RUN.
REQ-034 rst asserted mid-RUN with count=7: next cycle count=0, busy=0, out=0, wrap=0; a start during rst is ignored.
REQ-035 CHANNELS=4, WIDTH=8, channel periods 0,1,254,255 in continuous mode: wraps every 1, 2, 255 and 256 cycles, with no interference between channels.
